class0_score_accumulator: RTL and testbench

Sequential stage directly downstream of the 7-input class-0 popcount adder. It accepts one 3-bit popcount per beat over a valid/ready handshake and sums a fixed number of beats into a per-frame class score. Each frame yields a registered score and a threshold-hit flag on a valid/ready output. It sits between the class-0 popcount tree and the class-decision logic.

---
 rtl/class0_score_accumulator_if.sv | 27 ++
 rtl/class0_score_accumulator.sv | 78 +++++++
 tb/tb_class0_score_accumulator.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/class0_score_accumulator_if.sv
// Handshake bundle between the class-0 popcount tree, the score
// accumulator and the class-decision logic.
interface class0_score_accumulator_if #(
   parameter int CNT_W   = 3,
   parameter int SCORE_W = 7
);
   logic               in_valid;
   logic               in_ready;
   logic [CNT_W-1:0]   in_count;
   logic [SCORE_W-1:0] thresh;
   logic               out_valid;
   logic               out_ready;
   logic [SCORE_W-1:0] out_score;
   logic               out_hit;

   // Upstream/downstream side that drives beats and consumes results.
   modport master (
      output in_valid, in_count, thresh, out_ready,
      input  in_ready, out_valid, out_score, out_hit
   );

   // Accumulator side.
   modport slave (
      input  in_valid, in_count, thresh, out_ready,
      output in_ready, out_valid, out_score, out_hit
   );
endinterface

// File: rtl/class0_score_accumulator.sv
// Sums BEATS popcount beats into one class-0 frame score and flags whether
// the score reaches the threshold sampled on the frame's final beat.
// The result register frees the input side for all but the final beat, so
// the next frame keeps streaming while a result waits for its consumer.
module class0_score_accumulator #(
   parameter int CNT_W   = 3,
   parameter int BEATS   = 16,
   parameter int SCORE_W = 7
) (
   input logic                        clk,
   input logic                        rst,
   class0_score_accumulator_if.slave  bus
);
   localparam int CNT_BW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_BW-1:0] LAST_BEAT = CNT_BW'(BEATS - 1);

   logic [SCORE_W-1:0] acc_q, acc_d;
   logic [CNT_BW-1:0]  cnt_q, cnt_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               hit_q, hit_d;
   logic               vld_q, vld_d;
   logic               last_beat;
   logic               accept;
   logic [SCORE_W-1:0] sum;

   // Only the final beat stalls, and only while the previous result is unread.
   assign last_beat    = (cnt_q == LAST_BEAT);
   assign bus.in_ready = !rst && !(vld_q && !bus.out_ready && last_beat);
   assign accept       = bus.in_valid && bus.in_ready;
   assign sum          = acc_q + SCORE_W'(bus.in_count);

   assign bus.out_valid = vld_q;
   assign bus.out_score = score_q;
   assign bus.out_hit   = hit_q;

   // Next-state: accumulate, close the frame on the last beat, retire results.
   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      score_d = score_q;
      hit_d   = hit_q;
      vld_d   = vld_q;
      if (vld_q && bus.out_ready) begin
         vld_d = 1'b0;
      end
      if (accept) begin
         if (last_beat) begin
            // A frame closing in the same cycle the old result is taken
            // overrides the clear, giving back-to-back results.
            score_d = sum;
            hit_d   = (sum >= bus.thresh);
            vld_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_BW'(1);
         end
      end
   end

   // State registers with synchronous reset; reset drops partial frames and pending results.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         score_q <= '0;
         hit_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         score_q <= score_d;
         hit_q   <= hit_d;
         vld_q   <= vld_d;
      end
   end
endmodule

// File: tb/tb_class0_score_accumulator.sv
// Self-checking bench for class0_score_accumulator: a frame-level model
// (list of accepted beats per frame, summed when the frame fills) is checked
// against the DUT every cycle, plus directed frames with literal results.
module tb_class0_score_accumulator;
   localparam int CNT_W   = 3;
   localparam int BEATS   = 16;
   localparam int SCORE_W = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   pulses = 0;
   bit   prev_vld = 1'b0;

   class0_score_accumulator_if #(.CNT_W(CNT_W), .SCORE_W(SCORE_W)) bus ();

   class0_score_accumulator #(.CNT_W(CNT_W), .BEATS(BEATS), .SCORE_W(SCORE_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model state: beats accepted so far in the current frame, and the
   // result register as seen by the consumer.
   int frame[$];
   bit m_vld = 1'b0;
   int m_score = 0;
   bit m_hit = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_ready();
      return !rst && !(m_vld && !bus.out_ready && frame.size() == BEATS - 1);
   endfunction

   // Model update on each rising edge from the inputs applied in that cycle.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         frame.delete();
         m_vld = 1'b0;
         m_score = 0;
         m_hit = 1'b0;
      end else begin
         bit rdy;
         rdy = exp_ready();
         if (m_vld && bus.out_ready) m_vld = 1'b0;
         if (bus.in_valid && rdy) begin
            frame.push_back(int'(bus.in_count));
            if (frame.size() == BEATS) begin
               int total;
               total = 0;
               foreach (frame[i]) total += frame[i];
               m_score = total % (1 << SCORE_W);
               m_hit = (m_score >= int'(bus.thresh));
               m_vld = 1'b1;
               frame.delete();
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("in_ready", int'(bus.in_ready), int'(exp_ready()));
      chk("out_valid", int'(bus.out_valid), int'(m_vld));
      chk("out_score", int'(bus.out_score), m_score);
      chk("out_hit", int'(bus.out_hit), int'(m_hit));
      if (bus.out_valid && !prev_vld) pulses++;
      prev_vld = bus.out_valid;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until accepted (bounded).
   task automatic send_beat(input int cnt);
      int  waited;
      bit  ok;
      waited = 0;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_count = CNT_W'(cnt);
      while (!ok && waited < 100) begin
         @(negedge clk);
         ok = bus.in_ready;
         step();
         waited++;
      end
      bus.in_valid = 1'b0;
      bus.in_count = CNT_W'($urandom);
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL beat_accept: got timeout, expected acceptance within 100 cycles");
      end
   endtask

   initial begin
      int c0;
      bus.in_valid  = 1'b0;
      bus.in_count  = '0;
      bus.thresh    = '0;
      bus.out_ready = 1'b1;

      // Reset state
      step(); step();
      chk("rst_in_ready", int'(bus.in_ready), 0);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_score", int'(bus.out_score), 0);
      chk("rst_in_ready_release", int'(bus.in_ready), 1);

      // All-max frame
      bus.thresh = 7'd100;
      for (int k = 0; k < BEATS; k++) send_beat(7);
      chk("allmax_valid", int'(bus.out_valid), 1);
      chk("allmax_score", int'(bus.out_score), 112);
      chk("allmax_hit", int'(bus.out_hit), 1);
      chk("allmax_model", m_score, 112);
      step();
      chk("allmax_one_cycle", int'(bus.out_valid), 0);

      // Ramp frame, threshold just above and exactly at the score
      bus.thresh = 7'd57;
      for (int k = 0; k < BEATS; k++) send_beat(k % 8);
      chk("ramp57_score", int'(bus.out_score), 56);
      chk("ramp57_hit", int'(bus.out_hit), 0);
      bus.thresh = 7'd56;
      for (int k = 0; k < BEATS; k++) send_beat(k % 8);
      chk("ramp56_score", int'(bus.out_score), 56);
      chk("ramp56_hit", int'(bus.out_hit), 1);
      chk("ramp56_model_hit", int'(m_hit), 1);

      // Backpressure: A waits while B streams; B's last beat stalls
      bus.thresh = 7'd0;
      step();
      for (int k = 0; k < BEATS; k++) send_beat(1);
      bus.out_ready = 1'b0;
      chk("bp_a_score", int'(bus.out_score), 16);
      c0 = cyc;
      for (int k = 0; k < BEATS - 1; k++) send_beat(2);
      chk("bp_b_cycles", cyc - c0, BEATS - 1);
      bus.in_valid = 1'b1;
      bus.in_count = CNT_W'(2);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_stall_ready", int'(bus.in_ready), 0);
         chk("bp_hold_score", int'(bus.out_score), 16);
         chk("bp_hold_valid", int'(bus.out_valid), 1);
         step();
      end
      // Release: final beat of B accepted in the same cycle A is taken
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", int'(bus.in_ready), 1);
      step();
      bus.in_valid = 1'b0;
      chk("simul_valid", int'(bus.out_valid), 1);
      chk("simul_score", int'(bus.out_score), 32);
      step();
      chk("simul_retired", int'(bus.out_valid), 0);

      // Reset mid-frame
      for (int k = 0; k < 5; k++) send_beat(7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_valid", int'(bus.out_valid), 0);
      c0 = pulses;
      for (int k = 0; k < BEATS; k++) send_beat(3);
      chk("midrst_score", int'(bus.out_score), 48);
      chk("midrst_valid_after", int'(bus.out_valid), 1);
      step();
      chk("midrst_pulses", pulses - c0, 1);

      // Sparse ramp frame
      bus.thresh = 7'd57;
      c0 = pulses;
      for (int k = 0; k < BEATS; k++) begin
         while ($urandom_range(0, 1) == 1) begin
            bus.in_count = CNT_W'($urandom);
            step();
         end
         send_beat(k % 8);
      end
      chk("sparse_score", int'(bus.out_score), 56);
      step();
      chk("sparse_pulses", pulses - c0, 1);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_count  = CNT_W'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.thresh    = SCORE_W'($urandom_range(0, 127));
         rst           = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;
      bus.in_valid = 1'b0;
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
